cla_bist_checker: RTL
=====================

Name: cla_bist_checker

Overview:
- Built-in self-test controller for the WIDTH-bit carry look-ahead adder. It sits on the other side of the adder's a/b/cin -> s/cout interface.
- Drives every operand combination {cin,b,a} exhaustively into the adder.
- Compares each returned s/cout against an internal reference sum and reports pass/fail, the error count and the first failing vector.
- Replaces manual vector lists with on-chip, repeatable checking.

Parameters:
- WIDTH, 4: adder operand width in bits.
- LAT, 0: adder result latency in clock cycles, range 0..3 (0 = combinational adder).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a test run; sampled only in IDLE or DONE.
- a_o  output  WIDTH  operand a to the adder.
- b_o  output  WIDTH  operand b to the adder.
- cin_o  output  1  carry-in to the adder.
- s_i  input  WIDTH  sum from the adder.
- cout_i  input  1  carry-out from the adder.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  high in DONE; held until the next start.
- pass  output  1  done && err_count==0.
- err_count  output  2*WIDTH+2  number of mismatching vectors; saturates at all-ones.
- first_err_vec  output  2*WIDTH+1  vector index of the first mismatch.
- first_err_valid  output  1  first_err_vec holds a captured index.

Behaviour:
- Reset (async assert, sync release): state=IDLE. a_o, b_o, cin_o, busy, done, pass, err_count, first_err_vec and first_err_valid are all 0. Internal vector counter and expected-value pipeline are cleared.
- Vector index v, 2*WIDTH+1 bits: a=v[WIDTH-1:0], b=v[2W-1:W], cin=v[2W]. NV=2^(2W+1) (512 for W=4).
- Expected value for vector v is the (WIDTH+1)-bit sum a+b+cin, formatted {cout,s}.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE, start=1 at an edge:
  - go to RUN; v=0; err_count, first_err_* and done cleared.
  - a_o/b_o/cin_o show vector 0 in the cycle that follows.
- RUN:
  - Operands are registered outputs of v. At each edge v increments.
  - The expected value of the currently presented vector enters a LAT-deep shift pipeline (LAT=0: used directly).
  - Leaving RUN: after the edge that presents v=NV-1 completes, go to DRAIN if LAT>0, else DONE.
- DRAIN: lasts exactly LAT cycles. Operands hold the last vector; no new expected entries are issued. Then go to DONE.
- Compare rule:
  - The response to the vector presented in cycle t is sampled at the edge ending cycle t+LAT, comparing {cout_i,s_i} with the pipelined expected value.
  - Compares are qualified by a valid bit travelling with the pipeline, so no compare occurs before the first response or after the last.
  - Exactly NV compares per run.
- On mismatch:
  - err_count increments, saturating.
  - If first_err_valid=0, capture that vector's index into first_err_vec and set first_err_valid.
- Timing: busy is high for exactly NV+LAT cycles. done and pass assert on the same edge busy drops.
- start while busy: ignored.
- start held high in DONE: a new run is launched each time DONE is reached.
- Reset mid-run: immediate return to IDLE with all reset values. Partial results are discarded.
- Operand outputs in DONE: hold the last vector.

Test Plan:
- Ideal combinational adder, W=4, LAT=0, start pulse: busy high 512 cycles; done=1, pass=1, err_count=0, first_err_valid=0; operand sequence is v=0..511 in order.
- Adder with s[0] stuck-at-0: err_count=256, first_err_vec=1 (a=1,b=0,cin=0), pass=0.
- Adder with cout stuck-at-0: err_count=256, first_err_vec=31 (a=15,b=1,cin=0), pass=0.
- LAT=2 with a 2-stage registered ideal adder: busy high 514 cycles, pass=1. Same checker against a combinational adder: err_count!=0, pass=0.
- rst_n low for 1 cycle at v=100: all outputs 0 immediately, state IDLE. Next start runs the full 512 vectors with pass=1.
- start pulsed at v=50 during RUN: no restart; run ends at 512 cycles with unchanged results.

Source files
------------

// File: rtl/cla_bist_checker.sv
// rtl/cla_bist_checker.sv - exhaustive BIST driver/checker for a WIDTH-bit adder
// Sweeps every {cin,b,a}, compares {cout,s} against a LAT-delayed reference sum.
module cla_bist_checker #(
  parameter int WIDTH = 4,
  parameter int LAT   = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [WIDTH-1:0]     a_o,
  output logic [WIDTH-1:0]     b_o,
  output logic                 cin_o,
  input  logic [WIDTH-1:0]     s_i,
  input  logic                 cout_i,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH+1:0]   err_count,
  output logic [2*WIDTH:0]     first_err_vec,
  output logic                 first_err_valid
);

  localparam int VW = 2*WIDTH + 1;
  localparam int EW = WIDTH + 1;
  localparam int CW = 2*WIDTH + 2;
  localparam logic [VW-1:0] V_LAST     = '1;
  localparam logic [1:0]    DRAIN_LAST = 2'(LAT > 0 ? LAT - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [VW-1:0]   r_v;
  logic [1:0]      r_drain;
  logic [CW-1:0]   r_err;
  logic [VW-1:0]   r_fev;
  logic            r_fv;

  logic            w_launch;
  logic            w_push;
  logic [EW-1:0]   w_exp;
  logic            w_cmp_vld;
  logic [EW-1:0]   w_cmp_exp;
  logic [VW-1:0]   w_cmp_idx;
  logic            w_mis;

  assign w_launch = ((r_state == S_IDLE) || (r_state == S_DONE)) && start;
  assign w_push   = (r_state == S_RUN);
  assign w_exp    = {1'b0, r_v[WIDTH-1:0]} + {1'b0, r_v[2*WIDTH-1:WIDTH]} + EW'(r_v[VW-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (r_v == V_LAST) w_next = (LAT > 0) ? S_DRAIN : S_DONE;
      S_DRAIN: if (r_drain == DRAIN_LAST) w_next = S_DONE;
      S_DONE:  if (start) w_next = S_RUN;
      default: w_next = S_IDLE;
    endcase
  end

  // r_v is both the presented vector index and the operand register; it holds in DRAIN/DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v     <= '0;
      r_drain <= '0;
    end else begin
      if (w_launch) begin
        r_v <= '0;
      end else if (w_push && (r_v != V_LAST)) begin
        r_v <= r_v + 1'b1;
      end
      if (r_state == S_DRAIN) begin
        r_drain <= r_drain + 1'b1;
      end else begin
        r_drain <= '0;
      end
    end
  end

  generate
    if (LAT == 0) begin : g_comb
      assign w_cmp_vld = w_push;
      assign w_cmp_exp = w_exp;
      assign w_cmp_idx = r_v;
    end else begin : g_pipe
      logic [LAT-1:0] r_vld;
      logic [EW-1:0]  r_exp [LAT];
      logic [VW-1:0]  r_idx [LAT];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_vld <= '0;
          for (int i = 0; i < LAT; i++) begin
            r_exp[i] <= '0;
            r_idx[i] <= '0;
          end
        end else begin
          r_vld[0] <= w_push;
          r_exp[0] <= w_exp;
          r_idx[0] <= r_v;
          for (int i = 1; i < LAT; i++) begin
            r_vld[i] <= r_vld[i-1];
            r_exp[i] <= r_exp[i-1];
            r_idx[i] <= r_idx[i-1];
          end
        end
      end

      assign w_cmp_vld = r_vld[LAT-1];
      assign w_cmp_exp = r_exp[LAT-1];
      assign w_cmp_idx = r_idx[LAT-1];
    end
  endgenerate

  assign w_mis = w_cmp_vld && ({cout_i, s_i} != w_cmp_exp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= '0;
      r_fev <= '0;
      r_fv  <= 1'b0;
    end else if (w_launch) begin
      r_err <= '0;
      r_fev <= '0;
      r_fv  <= 1'b0;
    end else if (w_mis) begin
      if (r_err != '1) begin
        r_err <= r_err + 1'b1;
      end
      if (!r_fv) begin
        r_fev <= w_cmp_idx;
        r_fv  <= 1'b1;
      end
    end
  end

  assign a_o             = r_v[WIDTH-1:0];
  assign b_o             = r_v[2*WIDTH-1:WIDTH];
  assign cin_o           = r_v[VW-1];
  assign busy            = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done            = (r_state == S_DONE);
  assign pass            = done && (r_err == '0);
  assign err_count       = r_err;
  assign first_err_vec   = r_fev;
  assign first_err_valid = r_fv;

endmodule
